// File: rtl/aux_run_ctrl_pkg.sv
// Shared definitions for the run/stop sequencer.
// Contents: the FSM state codes, the stop-cause codes, the width of the
// step counter, and a helper that identifies the stopped states.
package aux_run_ctrl_pkg;

  localparam int unsigned STEP_BIT = 8;
  localparam logic [STEP_BIT-1:0] STEP_ONE = {{(STEP_BIT-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_STEP    = 3'd2,
    ST_HALTED  = 3'd3,
    ST_BREAK   = 3'd4,
    ST_PAUSED  = 3'd5
  } run_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_HALT = 2'b01,
    CAUSE_BP   = 2'b10,
    CAUSE_STEP = 2'b11
  } stop_cause_e;

  // Only RUN and STEP let the core advance; every other state waits for go.
  function automatic logic is_running(input run_state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/aux_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter,
// debounced level and a one-cycle pulse on the debounced rising edge.
// Ports:
//   clk, rst   core clock, synchronous active-high reset
//   i_raw      raw asynchronous, bouncy button
//   o_go       one-cycle pulse when the debounced level rises
module aux_debounce
  import aux_run_ctrl_pkg::*;
#(
  parameter logic [15:0] DebounceCnt = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_go
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_level;
  logic        r_go;
  logic [15:0] r_cnt;
  logic        w_diff;
  logic        w_done;

  // The counter measures how long the synced value has disagreed with the
  // accepted level; the level flips only after DebounceCnt such samples.
  assign w_diff = (r_sync2 != r_level);
  assign w_done = w_diff && (r_cnt == (DebounceCnt - 16'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_go    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_go    <= w_done && r_sync2;
      if (!w_diff || w_done) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_done) begin
        r_level <= r_sync2;
      end
    end
  end

  assign o_go = r_go;

endmodule

// File: rtl/aux_run_ctrl.sv
// Run/stop sequencer for the pipelined core. Produces the core and
// performance-counter enable from a debounced resume button, the core halt
// flag, a PC breakpoint comparator and an N-instruction step counter.
// Ports:
//   clk, rst    core clock, synchronous active-high reset
//   resume      raw pushbutton (asynchronous, bouncy)
//   step_mode   1 = step N instructions, 0 = free run (sampled on resume)
//   step_cnt    instructions per step, 0 behaves as 1 (sampled on resume)
//   bp_en       breakpoint enable
//   bp_addr     breakpoint PC
//   pc          current core PC
//   halt        core halted (syscall stop)
//   en          core / counter enable
//   state       current FSM state code
//   stop_cause  00 none, 01 halt, 10 breakpoint, 11 step done
module aux_run_ctrl
  import aux_run_ctrl_pkg::*;
#(
  parameter logic [15:0] DebounceCnt = 16'd50000,
  parameter int unsigned PcBit       = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                resume,
  input  logic                step_mode,
  input  logic [STEP_BIT-1:0] step_cnt,
  input  logic                bp_en,
  input  logic [PcBit-1:0]    bp_addr,
  input  logic [PcBit-1:0]    pc,
  input  logic                halt,
  output logic                en,
  output logic [2:0]          state,
  output logic [1:0]          stop_cause
);

  run_state_e          r_state;
  stop_cause_e         r_cause;
  logic [STEP_BIT-1:0] r_remaining;
  logic                r_skip;

  logic                w_go;
  logic                w_bp_hit;
  logic                w_stop;
  logic                w_en;
  logic [STEP_BIT-1:0] w_step_load;

  aux_debounce #(
    .DebounceCnt(DebounceCnt)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .i_raw(resume),
    .o_go (w_go)
  );

  assign w_bp_hit    = bp_en && (pc == bp_addr);
  // skip masks the stop condition for the one instruction that caused the
  // previous stop, so a resume from HALTED/BREAK makes progress.
  assign w_stop      = !r_skip && (halt || w_bp_hit);
  // Combinational so the instruction at a breakpoint/halt never executes.
  assign w_en        = is_running(r_state) && !w_stop;
  assign w_step_load = (step_cnt == '0) ? STEP_ONE : step_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cause     <= CAUSE_NONE;
      r_remaining <= '0;
      r_skip      <= 1'b0;
    end else begin
      if (w_en) begin
        r_skip <= 1'b0;
      end
      case (r_state)
        ST_RUN: begin
          if (w_stop) begin
            r_state <= halt ? ST_HALTED : ST_BREAK;
            r_cause <= halt ? CAUSE_HALT : CAUSE_BP;
          end
        end
        ST_STEP: begin
          // A stop on the last step wins and leaves remaining untouched.
          if (w_stop) begin
            r_state <= halt ? ST_HALTED : ST_BREAK;
            r_cause <= halt ? CAUSE_HALT : CAUSE_BP;
          end else if (w_en) begin
            if (r_remaining == STEP_ONE) begin
              r_state <= ST_PAUSED;
              r_cause <= CAUSE_STEP;
            end else begin
              r_remaining <= r_remaining - STEP_ONE;
            end
          end
        end
        default: begin
          if (w_go) begin
            r_state     <= step_mode ? ST_STEP : ST_RUN;
            r_remaining <= w_step_load;
            r_cause     <= CAUSE_NONE;
            r_skip      <= (r_state == ST_HALTED) || (r_state == ST_BREAK);
          end
        end
      endcase
    end
  end

  assign en         = w_en;
  assign state      = r_state;
  assign stop_cause = r_cause;

endmodule

// File: tb/tb_aux_run_ctrl.sv
// Self-checking bench for aux_run_ctrl with DebounceCnt=4: directed
// scenarios followed by randomized stimulus, all compared cycle by cycle
// against a behavioural model of the run/stop rules.
module tb_aux_run_ctrl;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        resume;
  logic        step_mode;
  logic [7:0]  step_cnt;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic        halt;
  logic        en;
  logic [2:0]  state;
  logic [1:0]  stop_cause;

  always #5 clk = ~clk;

  aux_run_ctrl #(
    .DebounceCnt(16'd4),
    .PcBit      (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .resume    (resume),
    .step_mode (step_mode),
    .step_cnt  (step_cnt),
    .bp_en     (bp_en),
    .bp_addr   (bp_addr),
    .pc        (pc),
    .halt      (halt),
    .en        (en),
    .state     (state),
    .stop_cause(stop_cause)
  );

  int n_pass  = 0;
  int n_total = 0;
  int g_en    = 0;
  int g_starts = 0;
  logic [2:0] prev_st;

  // Model: running/stepping flags, stop reason, instructions still allowed,
  // the delay line of the button synchronizer and the debounce history.
  bit m_run, m_stepping, m_skip, m_go, m_lvl;
  int m_cause, m_left, m_cnt;
  bit m_pipe[2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic bit m_stop();
    return !m_skip && (halt || (bp_en && (pc == bp_addr)));
  endfunction

  function automatic bit m_en();
    return m_run && !m_stop();
  endfunction

  function automatic logic [2:0] m_state();
    if (m_run) return m_stepping ? 3'd2 : 3'd1;
    case (m_cause)
      0:       return 3'd0;
      1:       return 3'd3;
      2:       return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  task automatic model_reset();
    m_run = 0; m_stepping = 0; m_skip = 0; m_go = 0; m_lvl = 0;
    m_cause = 0; m_left = 0; m_cnt = 0;
    m_pipe[0] = 0; m_pipe[1] = 0;
  endtask

  task automatic model_edge(input bit e, input bit stp);
    bit s, go_now;
    s = m_pipe[0];
    m_pipe[0] = m_pipe[1];
    m_pipe[1] = resume;
    go_now = m_go;
    m_go = 0;
    if (s != m_lvl) begin
      m_cnt++;
      if (m_cnt == N) begin
        m_lvl = s;
        m_go = s;
        m_cnt = 0;
      end
    end else begin
      m_cnt = 0;
    end
    if (!m_run) begin
      if (go_now) begin
        m_skip     = (m_cause == 1) || (m_cause == 2);
        m_run      = 1;
        m_stepping = step_mode;
        m_left     = (step_cnt == 0) ? 1 : int'(step_cnt);
        m_cause    = 0;
      end
    end else begin
      if (e) m_skip = 0;
      if (stp) begin
        m_run = 0;
        m_cause = halt ? 1 : 2;
      end else if (m_stepping) begin
        m_left--;
        if (m_left == 0) begin
          m_run = 0;
          m_cause = 3;
        end
      end
    end
  endtask

  task automatic step(input string tag);
    bit e, stp;
    #1;
    check({tag, ".state"}, {29'd0, state}, {29'd0, m_state()});
    check({tag, ".en"}, {31'd0, en}, {31'd0, m_en()});
    check({tag, ".cause"}, {30'd0, stop_cause}, 32'(m_cause));
    if (en === 1'b1) g_en++;
    if ((prev_st inside {3'd0, 3'd3, 3'd4, 3'd5}) && (state inside {3'd1, 3'd2})) g_starts++;
    prev_st = state;
    e = m_en();
    stp = m_stop();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(e, stp);
    #1;
    if (e) pc = pc + 32'd4;
  endtask

  task automatic press(input int bounces, input string tag);
    for (int b = 0; b < bounces; b++) begin
      resume = 1'b1; step(tag); step(tag);
      resume = 1'b0; step(tag); step(tag);
    end
    resume = 1'b1;
    repeat (9) step(tag);
    resume = 1'b0;
    repeat (9) step(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b1; resume = 1'b0; step_mode = 1'b0; step_cnt = 8'd0;
    bp_en = 1'b0; bp_addr = 32'd0; pc = 32'd0; halt = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    prev_st = 3'd0;
    check("reset.state", {29'd0, state}, 32'd0);
    check("reset.en", {31'd0, en}, 32'd0);
    check("reset.cause", {30'd0, stop_cause}, 32'd0);
    rst = 1'b0;

    // Clean press, free run: RUN appears 7 edges after the press.
    resume = 1'b1;
    k = 0;
    while (state !== 3'd1 && k < 20) begin step("press"); k++; end
    check("go_latency", 32'(k), 32'd7);
    check("run.en", {31'd0, en}, 32'd1);
    check("run.cause", {30'd0, stop_cause}, 32'd0);
    resume = 1'b0;
    repeat (9) step("release");

    // Breakpoint three instructions ahead.
    bp_addr = pc + 32'd12;
    bp_en = 1'b1;
    k = 0;
    while (state !== 3'd4 && k < 20) begin step("to_bp"); k++; end
    check("bp.state", {29'd0, state}, 32'd4);
    check("bp.en", {31'd0, en}, 32'd0);
    check("bp.cause", {30'd0, stop_cause}, 32'd2);
    check("bp.pc", pc, bp_addr);

    // Bouncy press resumes exactly once and steps past the breakpoint.
    g_starts = 0;
    press(3, "bounce");
    check("bounce.one_go", 32'(g_starts), 32'd1);
    check("bounce.running", {29'd0, state}, 32'd1);
    check("bounce.past_bp", {31'd0, pc > bp_addr}, 32'd1);

    // Halt and breakpoint together: halt has priority.
    bp_addr = pc;
    halt = 1'b1;
    step("halt_bp");
    check("hb.state", {29'd0, state}, 32'd3);
    check("hb.cause", {30'd0, stop_cause}, 32'd1);
    g_en = 0;
    press(0, "halt_resume");
    check("halt.one_en", 32'(g_en), 32'd1);
    check("halt.again", {29'd0, state}, 32'd3);
    halt = 1'b0;
    bp_en = 1'b0;

    // Step mode with three and with zero instructions.
    step_mode = 1'b1;
    step_cnt = 8'd3;
    g_en = 0;
    press(0, "step3");
    check("step3.en_cycles", 32'(g_en), 32'd3);
    check("step3.state", {29'd0, state}, 32'd5);
    check("step3.cause", {30'd0, stop_cause}, 32'd3);
    step_cnt = 8'd0;
    g_en = 0;
    press(0, "step0");
    check("step0.en_cycles", 32'(g_en), 32'd1);
    check("step0.state", {29'd0, state}, 32'd5);

    // Reset in the middle of a step burst, with the button held.
    step_cnt = 8'd5;
    g_en = 0;
    resume = 1'b1;
    k = 0;
    while (g_en < 3 && k < 30) begin step("step5"); k++; end
    check("step5.progress", 32'(g_en), 32'd3);
    rst = 1'b1;
    step("rst_mid");
    check("rst_mid.state", {29'd0, state}, 32'd0);
    check("rst_mid.en", {31'd0, en}, 32'd0);
    check("rst_mid.cause", {30'd0, stop_cause}, 32'd0);
    repeat (10) step("rst_hold");
    check("rst_hold.nogo", {29'd0, state}, 32'd0);
    rst = 1'b0;
    resume = 1'b0;
    repeat (10) step("post_rst");
    check("post_rst.idle", {29'd0, state}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) resume = ~resume;
      halt = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) begin
        bp_en = 1'($urandom_range(0, 1));
        bp_addr = pc + 32'($urandom_range(0, 5)) * 32'd4;
      end
      if ($urandom_range(0, 29) == 0) begin
        step_mode = 1'($urandom_range(0, 1));
        step_cnt = 8'($urandom_range(0, 4));
      end
      rst = ($urandom_range(0, 199) == 0);
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
